// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array front end.
package tpu_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    // Address/counter width helper: never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. Full/empty come straight from
// the occupancy register, so there is no combinational path from pop to full.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     push,
    input  logic [WIDTH-1:0]                         wdata,
    input  logic                                     pop,
    output logic [WIDTH-1:0]                         rdata,
    output logic                                     full,
    output logic                                     empty,
    output logic [tpu_pkg::clog2_min1(DEPTH):0]      count
);
    import tpu_pkg::*;

    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == (AW + 1)'(DEPTH));
    assign empty   = (occ == '0);
    assign count   = occ;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave occupancy alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/input_skew_feeder.sv
// West-edge feeder for the systolic array: buffers activation vectors, then
// emits one per cycle during a tile with row r delayed by r cycles so the
// array sees a diagonal wavefront. The first vector of a tile carries the
// weight switch pulse.
module input_skew_feeder #(
    parameter int ROWS       = 2,
    parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_vecs,
    input  logic [ROWS*DATA_WIDTH-1:0] in_vec,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ROWS*DATA_WIDTH-1:0] row_input_out,
    output logic [ROWS-1:0]            row_valid_out,
    output logic [ROWS-1:0]            row_switch_out,
    output logic                       busy,
    output logic                       done
);
    import tpu_pkg::*;

    localparam int VW  = ROWS * DATA_WIDTH;
    localparam int DCW = clog2_min1(ROWS);
    localparam int FCW = clog2_min1(FIFO_DEPTH) + 1;

    feeder_state_t    state;
    feeder_state_t    state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nxt;
    logic             first;
    logic             first_nxt;
    logic [DCW-1:0]   drain_cnt;
    logic [DCW-1:0]   drain_cnt_nxt;
    logic             done_nxt;

    logic             fifo_push;
    logic             fifo_pop;
    logic [VW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    logic [VW-1:0]    s0_data;
    logic             s0_valid;
    logic             s0_switch;

    // in_ready depends only on registered occupancy.
    assign in_ready  = (fifo_count != FCW'(FIFO_DEPTH));
    assign fifo_push = in_valid && !fifo_full;
    assign busy      = (state != IDLE);

    sync_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (in_vec),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM and tile counters register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            first     <= 1'b0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            first     <= first_nxt;
            drain_cnt <= drain_cnt_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic. A zero-length tile enters DRAIN with the counter
    // already at its terminal value so done follows one cycle later.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        first_nxt     = first;
        drain_cnt_nxt = drain_cnt;
        done_nxt      = 1'b0;
        fifo_pop      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        remaining_nxt = num_vecs;
                        first_nxt     = 1'b1;
                        state_nxt     = STREAM;
                    end else begin
                        drain_cnt_nxt = DCW'(ROWS - 1);
                        state_nxt     = DRAIN;
                    end
                end
            end
            STREAM: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    first_nxt     = 1'b0;
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        drain_cnt_nxt = '0;
                        state_nxt     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DCW'(ROWS - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt + DCW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage 0: popped vector or a zero-data bubble; never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_data   <= '0;
            s0_valid  <= 1'b0;
            s0_switch <= 1'b0;
        end else begin
            s0_data   <= fifo_pop ? fifo_rdata : '0;
            s0_valid  <= fifo_pop;
            s0_switch <= fifo_pop && first;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (r == 0) begin : g_direct
            assign row_input_out[0 +: DATA_WIDTH] = s0_data[0 +: DATA_WIDTH];
            assign row_valid_out[0]               = s0_valid;
            assign row_switch_out[0]              = s0_switch;
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] d_sr [r];
            logic                  v_sr [r];
            logic                  s_sr [r];

            // r-deep delay line for this row's data, valid and switch.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) begin
                        d_sr[i] <= '0;
                        v_sr[i] <= 1'b0;
                        s_sr[i] <= 1'b0;
                    end
                end else begin
                    d_sr[0] <= s0_data[r*DATA_WIDTH +: DATA_WIDTH];
                    v_sr[0] <= s0_valid;
                    s_sr[0] <= s0_switch;
                    for (int i = 1; i < r; i++) begin
                        d_sr[i] <= d_sr[i-1];
                        v_sr[i] <= v_sr[i-1];
                        s_sr[i] <= s_sr[i-1];
                    end
                end
            end

            assign row_input_out[r*DATA_WIDTH +: DATA_WIDTH] = d_sr[r-1];
            assign row_valid_out[r]                          = v_sr[r-1];
            assign row_switch_out[r]                         = s_sr[r-1];
        end
    end

endmodule

// File: tb/tb_input_skew_feeder.sv
// Directed bench for input_skew_feeder. A reference model assigns pushed
// vectors to tiles and queues the per-row {switch, data} each row must show;
// a negedge monitor pops and compares whenever a row is valid.
module tb_input_skew_feeder;

    localparam int ROWS  = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int VW    = ROWS * DW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_vecs = '0;
    logic [VW-1:0]    in_vec = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [VW-1:0]    row_input_out;
    logic [ROWS-1:0]  row_valid_out;
    logic [ROWS-1:0]  row_switch_out;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [VW-1:0] pend_q[$];
    logic [DW:0]   exp_q [ROWS][$];
    int            need = 0;
    bit            first_pend = 1'b0;

    logic [ROWS-1:0] hv [32];
    logic [ROWS-1:0] hs [32];
    int              nbusy;
    logic [DW:0]     mon_got;
    logic [DW:0]     mon_exp;

    input_skew_feeder #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vecs       (num_vecs),
        .in_vec         (in_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .row_input_out  (row_input_out),
        .row_valid_out  (row_valid_out),
        .row_switch_out (row_switch_out),
        .busy           (busy),
        .done           (done)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] mk(input int a, input int b);
        return {DW'(b), DW'(a)};
    endfunction

    // Move pending vectors into the row queues while the current tile wants them.
    function automatic void match();
        logic [VW-1:0] v;
        while (need > 0 && pend_q.size() > 0) begin
            v = pend_q.pop_front();
            for (int r = 0; r < ROWS; r++) begin
                exp_q[r].push_back({first_pend, v[r*DW +: DW]});
            end
            first_pend = 1'b0;
            need--;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [VW-1:0] v, input int budget);
        logic acc;
        int   w;
        acc = 1'b0;
        w = 0;
        in_valid = 1'b1;
        in_vec = v;
        while (!acc && w < budget) begin
            @(negedge clk);
            acc = in_ready;
            step();
            w++;
        end
        in_valid = 1'b0;
        in_vec = '0;
        if (acc) begin
            pend_q.push_back(v);
            match();
        end
        check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic start_tile(input int n);
        start = 1'b1;
        num_vecs = CNT_W'(n);
        step();
        start = 1'b0;
        num_vecs = '0;
        need += n;
        first_pend = (n > 0);
        match();
    endtask

    // Called in the first cycle after start is sampled (cycle 0).
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        nbusy = 0;
        for (int c = 0; c < 32; c++) begin
            hv[c] = '0;
            hs[c] = '0;
        end
        for (int c = 0; c < budget && lat < 0; c++) begin
            @(negedge clk);
            if (c < 32) begin
                hv[c] = row_valid_out;
                hs[c] = row_switch_out;
            end
            if (busy) nbusy++;
            if (done) lat = c;
        end
        step();
        check("done_seen", 64'(lat >= 0), 64'd1);
    endtask

    // Fully prefetched tile of n vectors: row r valid on cycles 1+r .. n+r.
    task automatic check_wave(input int n);
        logic [ROWS-1:0] ev;
        logic [ROWS-1:0] es;
        for (int c = 0; c < 32; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                ev[r] = (c >= 1 + r) && (c <= n + r);
                es[r] = (n > 0) && (c == 1 + r);
            end
            check($sformatf("wave_valid_c%0d", c), 64'(hv[c]), 64'(ev));
            check($sformatf("wave_switch_c%0d", c), 64'(hs[c]), 64'(es));
        end
    endtask

    // Scoreboard monitor: valid rows pop the row queue, idle rows must be zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            for (int r = 0; r < ROWS; r++) begin
                mon_got = {row_switch_out[r], row_input_out[r*DW +: DW]};
                if (exp_q[r].size() == 0) begin
                    checks++;
                    assert (row_valid_out[r] === 1'b0) else begin
                        errors++;
                        $error("FAIL row%0d_unexpected_valid observed=%0h expected=0", r, row_valid_out[r]);
                    end
                end else if (row_valid_out[r] === 1'b1) begin
                    mon_exp = exp_q[r].pop_front();
                    checks++;
                    assert (mon_got === mon_exp) else begin
                        errors++;
                        $error("FAIL row%0d_data observed=%0h expected=%0h", r, mon_got, mon_exp);
                    end
                end
                if (row_valid_out[r] !== 1'b1) begin
                    checks++;
                    assert (mon_got === '0) else begin
                        errors++;
                        $error("FAIL row%0d_bubble observed=%0h expected=0", r, mon_got);
                    end
                end
            end
        end
    end

    int lat;
    int d0;

    // Directed test sequence.
    initial begin
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_row_input", 64'(row_input_out), 64'd0);
        check("rst_row_valid", 64'(row_valid_out), 64'd0);
        check("rst_row_switch", 64'(row_switch_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Prefetch three vectors, then a tile of three.
        push_vec(mk(1, 2), 10);
        push_vec(mk(3, 4), 10);
        push_vec(mk(5, 6), 10);
        @(negedge clk);
        check("prefetch_in_ready", 64'(in_ready), 64'd1);
        check("prefetch_no_valid", 64'(row_valid_out), 64'd0);
        step();
        d0 = done_cnt;
        start_tile(3);
        wait_done(40, lat);
        check("t1_done_latency", 64'(lat), 64'd5);
        check("t1_busy_cycles", 64'(nbusy), 64'd5);
        check("t1_done_count", 64'(done_cnt - d0), 64'd1);
        check_wave(3);

        // Starvation mid-tile: three bubbles between the two vectors.
        d0 = done_cnt;
        fork
            begin
                start_tile(2);
                wait_done(40, lat);
            end
            begin
                push_vec(mk(7, 8), 10);
                repeat (3) step();
                push_vec(mk(9, 10), 10);
            end
        join
        check("t2_done_latency", 64'(lat), 64'd7);
        check("t2_done_count", 64'(done_cnt - d0), 64'd1);
        for (int c = 0; c <= 6; c++) begin
            check($sformatf("t2_row0_valid_c%0d", c), 64'(hv[c][0]), 64'((c == 1) || (c == 5)));
        end

        // Fill the FIFO, then stream with in_valid held for a fifth vector.
        push_vec(mk(11, 12), 10);
        push_vec(mk(13, 14), 10);
        push_vec(mk(15, 16), 10);
        push_vec(mk(17, 18), 10);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step();
        d0 = done_cnt;
        fork
            begin
                start_tile(4);
                wait_done(40, lat);
            end
            push_vec(mk(19, 20), 20);
        join
        check("t3_done_latency", 64'(lat), 64'd6);
        check("t3_done_count", 64'(done_cnt - d0), 64'd1);
        check_wave(4);
        @(negedge clk);
        check("t3_in_ready_after", 64'(in_ready), 64'd1);
        step();

        // Zero-length tile: busy one cycle, no wavefront, single done.
        d0 = done_cnt;
        start_tile(0);
        wait_done(20, lat);
        check("t4_done_latency", 64'(lat), 64'd1);
        check("t4_busy_cycles", 64'(nbusy), 64'd1);
        check("t4_done_count", 64'(done_cnt - d0), 64'd1);
        check_wave(0);

        // Second start while busy is ignored.
        push_vec(mk(21, 22), 10);
        d0 = done_cnt;
        fork
            begin
                start_tile(2);
                wait_done(40, lat);
            end
            begin
                step();
                start = 1'b1;
                num_vecs = CNT_W'(9);
                step();
                start = 1'b0;
                num_vecs = '0;
            end
        join
        check("t5_done_latency", 64'(lat), 64'd4);
        check("t5_busy_cycles", 64'(nbusy), 64'd4);
        check("t5_done_count", 64'(done_cnt - d0), 64'd1);
        check_wave(2);
        repeat (3) step();
        @(negedge clk);
        check("t5_idle_after", 64'(busy), 64'd0);
        step();

        // Reset mid-stream after the first vector reaches row 0.
        push_vec(mk(31, 32), 10);
        push_vec(mk(33, 34), 10);
        push_vec(mk(35, 36), 10);
        d0 = done_cnt;
        start_tile(3);
        step();
        rst = 1'b1;
        pend_q.delete();
        for (int r = 0; r < ROWS; r++) exp_q[r].delete();
        need = 0;
        first_pend = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_row_input", 64'(row_input_out), 64'd0);
        check("t6_row_valid", 64'(row_valid_out), 64'd0);
        check("t6_row_switch", 64'(row_switch_out), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        step();

        // Fresh single-vector tile after the abort.
        push_vec(mk(41, 42), 10);
        d0 = done_cnt;
        start_tile(1);
        wait_done(40, lat);
        check("t7_done_latency", 64'(lat), 64'd3);
        check("t7_busy_cycles", 64'(nbusy), 64'd3);
        check("t7_done_count", 64'(done_cnt - d0), 64'd1);
        check_wave(1);

        repeat (4) step();
        check("exp_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        check("pend_drained", 64'(pend_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
